// File: rtl/soqpsk_lut_arbiter.sv
// Round-robin arbiter sharing one SOQPSK pulse-shape ROM among several shaper requesters.
// Each grant launches a one-hot owner tag down a ROM_LAT+1 deep pipe.
// The final tag stage marks which requester owns the sample now on rom_q.
module soqpsk_lut_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

    // tag_q[0] is the grant register; tag_q[ROM_LAT] lines up with rom_q
    logic [NUM_REQ-1:0] tag_q [0:ROM_LAT];
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [PtrW-1:0]    last_grant_q;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [PtrW-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ADDR_W-1:0]  win_addr;

    // Round-robin search starting just after the last winner, wrapping modulo NUM_REQ
    always_comb begin : arb
        int unsigned     cand;
        logic [PtrW-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        // A requester granted this cycle still holds req; mask it to avoid a double grant
        eligible   = req & ~tag_q[0] & {NUM_REQ{enable}};
        win_found  = 1'b0;
        win_idx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (32'(last_grant_q) + off) % NUM_REQ;
            cand_idx = PtrW'(cand);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        win_onehot = '0;
        if (win_found) begin
            win_onehot[win_idx] = 1'b1;
        end
        win_addr = req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
    end

    // Grant, ROM address, pointer and owner-tag pipeline registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s <= ROM_LAT; s++) begin
                tag_q[s] <= '0;
            end
            rom_addr_q   <= '0;
            last_grant_q <= LastIdx;
        end else begin
            tag_q[0] <= win_onehot;
            for (int unsigned s = 1; s <= ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            if (win_found) begin
                rom_addr_q   <= win_addr;
                last_grant_q <= win_idx;
            end
        end
    end

    // Busy while a grant is out or any tag is still travelling to the ROM output
    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s <= ROM_LAT; s++) begin
            busy = busy | (|tag_q[s]);
        end
    end

    assign gnt         = tag_q[0];
    assign rd_valid    = tag_q[ROM_LAT];
    assign rom_address = rom_addr_q;
    assign rd_data     = rom_q;

endmodule

// File: tb/tb_soqpsk_lut_arbiter.sv
// Self-checking bench for soqpsk_lut_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based transaction model of the arbiter.
module tb_soqpsk_lut_arbiter;

    localparam int N   = 4;
    localparam int AW  = 9;
    localparam int DW  = 14;
    localparam int LAT = 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_q = '0;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            busy;

    always #5 clock = ~clock;

    soqpsk_lut_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (LAT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        int v;
        v = int'(a) * 29 + 3;
        return v[DW-1:0];
    endfunction

    // ROM with registered address and registered output: two cycles of latency
    logic [AW-1:0] rom_a_q = '0;
    always @(posedge clock) begin
        rom_a_q <= rom_address;
        rom_q   <= rom_f(rom_a_q);
    end

    // Transaction model: pointer, current grant, and a queue of outstanding reads
    typedef struct {
        int            due;
        int            owner;
        logic [AW-1:0] addr;
    } ret_t;

    ret_t          rq[$];
    int            cyc = 0;
    int            m_ptr = N - 1;
    logic [N-1:0]  m_gnt = '0;
    logic [AW-1:0] m_addr = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, compare outputs
    task automatic step();
        int            win;
        int            c;
        logic [N-1:0]  exp_v;
        logic [DW-1:0] exp_d;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            m_gnt  = '0;
            m_addr = '0;
            m_ptr  = N - 1;
            rq.delete();
        end else begin
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
            win = -1;
            for (int off = 1; off <= N; off++) begin
                c = (m_ptr + off) % N;
                if (win < 0 && req[c] && !m_gnt[c] && enable) win = c;
            end
            m_gnt = '0;
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                m_addr     = req_addr[win*AW +: AW];
                m_ptr      = win;
                rq.push_back('{cyc + LAT, win, m_addr});
            end
        end
        exp_v = '0;
        exp_d = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_v[rq[0].owner] = 1'b1;
            exp_d = rom_f(rq[0].addr);
        end
        #1;
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("rom_address", 32'(rom_address), 32'(m_addr));
        check("rd_valid", 32'(rd_valid), 32'(exp_v));
        check("busy", 32'(busy), 32'(rq.size() != 0));
        if (exp_v != '0) check("rd_data", 32'(rd_data), 32'(exp_d));
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        req      = '0;
        req_addr = '0;

        // Reset state
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // All four requesting: strict rotation starting at 0
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < N; i++) set_addr(i, AW'(10 * (i + 1)));
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_order", 32'(gnt), 32'(1 << (i % 4)));
            check("t1_addr", 32'(rom_address), 32'(10 * (i % 4 + 1)));
        end
        req = '0;
        repeat (4) step();

        // Lone requester: one grant every other cycle
        set_addr(2, 9'h1FF);
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_gnt", 32'(gnt), (i % 2 == 0) ? 32'h4 : 32'h0);
            if (i >= 2) begin
                check("t2_rv", 32'(rd_valid), (i % 2 == 0) ? 32'h4 : 32'h0);
                if (i % 2 == 0) check("t2_data", 32'(rd_data), 32'(rom_f(9'h1FF)));
            end
        end
        req = '0;
        repeat (4) step();

        // Pointer at 1: contested 0/1 goes to 0, then to 1
        req = 4'b0010;
        step();
        check("t3_g1", 32'(gnt), 32'h2);
        req = 4'b0011;
        step();
        check("t3_g0", 32'(gnt), 32'h1);
        step();
        check("t3_g1b", 32'(gnt), 32'h2);
        req = '0;
        repeat (4) step();

        // enable drop after gnt[3]: in-flight read still returns
        req = 4'b1000;
        step();
        check("t4_g3", 32'(gnt), 32'h8);
        req    = 4'b0011;
        enable = 1'b0;
        step();
        check("t4_nog", 32'(gnt), 32'h0);
        step();
        check("t4_rv3", 32'(rd_valid), 32'h8);
        step();
        check("t4_idle", 32'(busy), 32'h0);
        step();
        check("t4_hold", 32'(gnt), 32'h0);
        enable = 1'b1;
        step();
        check("t4_g0", 32'(gnt), 32'h1);
        req = '0;
        repeat (4) step();

        // Reset mid-flight drops the read and restores the pointer
        req = 4'b0010;
        step();
        check("t5_g1", 32'(gnt), 32'h2);
        req     = '0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req     = 4'b0110;
        step();
        check("t5_first", 32'(gnt), 32'h2);
        check("t5_drop", 32'(rd_valid), 32'h0);
        step();
        check("t5_second", 32'(gnt), 32'h4);
        check("t5_drop2", 32'(rd_valid), 32'h0);
        req = '0;
        repeat (4) step();

        // req[3] loses to 0 and is withdrawn: never granted
        req = 4'b1000;
        step();
        req = '0;
        repeat (3) step();
        req = 4'b1001;
        step();
        check("t6_g0", 32'(gnt), 32'h1);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_g3", 32'(gnt[3]), 32'h0);
            check("t6_no_rv3", 32'(rd_valid[3]), 32'h0);
        end

        // Random traffic including enable drops and occasional resets
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 63) != 0);
            enable  = ($urandom_range(0, 7) != 0);
            req     = N'($urandom);
            for (int r = 0; r < N; r++) set_addr(r, AW'($urandom));
            step();
        end
        reset_n = 1'b1;
        req     = '0;
        repeat (5) step();
        check("end_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soqpsk_lut_arbiter.md
# soqpsk_lut_arbiter

Round-robin arbiter sharing one SOQPSK pulse-shape lookup ROM (512 x 14, registered address and output) among several shaper requesters, e.g. the I and Q chains. It accepts per-requester read requests, drives the single ROM address port, and routes each returned sample back to its owner with a valid strobe aligned to the ROM latency. It sits between the SOQPSK shaping datapaths and the ROM instance in the modulator.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 9: ROM address width
- DATA_W, 14: ROM data width
- ROM_LAT, 2: cycles from ROM address presented to rom_q valid
- clock  in  1  single clock; all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  1 = new grants allowed; 0 = no new grants, in-flight reads complete
- req  in  NUM_REQ  per-requester read request, held until granted
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W], held with req
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- rom_address  out  ADDR_W  registered address to the ROM
- rom_q  in  DATA_W  ROM read data
- rd_valid  out  NUM_REQ  one-hot, one-cycle return strobe
- rd_data  out  DATA_W  returned sample; rom_q passed through unregistered
- busy  out  1  1 while any read is in flight or any gnt is high

## Operation
- Arbitration on every rising edge: eligible[i] = req[i] & ~gnt[i] & enable. A requester granted in the current cycle is ineligible at that edge, so no double grant of a still-held req.
- Round-robin: search starts at last_grant+1, ascending, wrapping modulo NUM_REQ; first eligible wins. last_grant updates only on a grant.
- On a win by k: gnt <= one-hot(k), rom_address <= req_addr[k], last_grant <= k. With no winner: gnt <= 0, rom_address holds its value.
- Requester contract: hold req and req_addr stable until gnt[i] is sampled high. It may present a new req/addr in the cycle after gnt.
- Tag pipeline: ROM_LAT+1 stages of one-hot owner tags. Stage 0 is gnt; the final stage drives rd_valid. rd_data = rom_q.
- Throughput: one access per cycle total under contention; a single requester alone gets at most one access every 2 cycles.
- enable low: gnt is 0 from the next edge. Tags already in the pipe still produce rd_valid. last_grant is retained.
- busy = |gnt | any tag stage nonzero.

## Timing
- Reset (reset_n low at an edge):
  - gnt = 0, rd_valid = 0, busy = 0, rom_address = 0.
  - All tag stages cleared; last_grant = NUM_REQ-1, so requester 0 wins first.
  - In-flight reads are dropped: no rd_valid is issued for them after reset.
- req sampled high at edge E yields gnt high in cycle E+1, with rom_address valid in the same cycle.
- rd_valid[k] and rd_data are valid in cycle E+1+ROM_LAT, i.e. ROM_LAT cycles after gnt.
- Returns arrive in grant order, one per cycle at most. rd_valid is never high for two requesters at once.
- Simultaneous requests are resolved purely by the round-robin pointer. No fixed priority exists except immediately after reset.
- req deasserted before being granted: the request is withdrawn and no grant is issued for it.

## Test plan
- Reset, then req=4'b1111 held (re-asserted after each gnt), addresses 10/20/30/40 → gnt order 0,1,2,3,0… one per cycle, rom_address 10,20,30,40. rd_valid matches the gnt order ROM_LAT=2 cycles later, and rd_data equals the ROM contents at those addresses.
- Only req[2] held continuously with addr 0x1FF → gnt[2] every other cycle, and rd_valid[2] with data ROM[511] two cycles after each gnt.
- req[1] granted, then req[0] and req[1] both asserted → 0 wins next (pointer 1 → search starts at 2, wraps to 0). Next contested grant goes to 1.
- enable dropped the cycle after gnt[3] with req=4'b0011 pending → no further gnt. rd_valid[3] still fires 2 cycles later, busy returns to 0. After enable rises, gnt[0] comes first.
- reset_n pulsed low one cycle after gnt[1] → rd_valid stays 0 for the dropped read. After release with req=4'b0110, gnt[1] precedes gnt[2] (pointer reset to 3).
- req[3] asserted one cycle then withdrawn while gnt[0] is active → no gnt[3] and no rd_valid[3] issued.
